instr_fetch_unit: RTL and testbench

- Parametrised, pipelined instruction-fetch stage.
- Owns the fetch PC and issues sequential read requests to instruction memory, tolerating variable memory latency.
- Buffers returned words with their PCs in a prefetch FIFO and hands them to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with flush of buffered and in-flight fetches. Sits between the PC-select logic and the decode stage.

---
 rtl/if_pkg.sv | 14 +
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/if_prefetch_fifo.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Low address bits cleared to force word alignment.
    localparam int unsigned ALIGN_LOW_MASK  = 3;
    localparam int unsigned DEFAULT_PC_STEP = 4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: PC redirect, instruction-memory request/response and decode handshake.
interface instr_fetch_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              i_en;
    logic              i_redirect;
    logic [ADDR_W-1:0] i_redirect_pc;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_gnt;
    logic [DATA_W-1:0] i_mem_data;
    logic              i_mem_data_valid;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_instr;
    logic [ADDR_W-1:0] o_pc;
    logic [ADDR_W-1:0] o_pc_next;

    modport master (
        input  i_en, i_redirect, i_redirect_pc, i_mem_gnt, i_mem_data, i_mem_data_valid, i_ready,
        output o_mem_req, o_mem_addr, o_valid, o_instr, o_pc, o_pc_next
    );

    modport slave (
        output i_en, i_redirect, i_redirect_pc, i_mem_gnt, i_mem_data, i_mem_data_valid, i_ready,
        input  o_mem_req, o_mem_addr, o_valid, o_instr, o_pc, o_pc_next
    );

endinterface

// File: rtl/if_prefetch_fifo.sv
// Synchronous prefetch FIFO with flush; head is read combinationally from storage.
// Caller guarantees space before pushing; flush dominates push and pop.
module if_prefetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign head_dat = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Pipelined fetch stage: credit-limited sequential requests, in-order responses into a prefetch FIFO.
// Memory data valid in cycle N reaches decode in N+1; decode stalls hold the head and throttle requests.
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       PC_STEP    = DEFAULT_PC_STEP
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);
    localparam int                CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int                ENT_W      = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(ALIGN_LOW_MASK);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] START_PC   = RESET_PC & ALIGN_MASK;

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     outstanding_nx;
    logic [CW-1:0]     drop_nx;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_used;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENT_W-1:0]  head_dat;
    logic [ADDR_W-1:0] head_pc;
    logic              req_acc;
    logic              rsp_keep;
    logic              rsp_drop;
    logic              pop;

    // Every in-flight request reserves a FIFO slot, so the buffer can never overflow.
    assign credit_used   = {1'b0, outstanding} + {1'b0, fifo_count};
    assign bus.o_mem_req = rst && bus.i_en && !bus.i_redirect
                         && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign bus.o_mem_addr = fetch_pc;

    assign req_acc  = bus.o_mem_req && bus.i_mem_gnt;
    assign rsp_keep = bus.i_mem_data_valid && !bus.i_redirect && (state != DRAIN) && !fifo_full;
    assign rsp_drop = bus.i_mem_data_valid && !bus.i_redirect && (state == DRAIN);
    assign pop      = !fifo_empty && bus.i_ready && !bus.i_redirect;

    always_comb begin
        outstanding_nx = outstanding;
        if (req_acc) begin
            outstanding_nx = outstanding_nx + CW'(1);
        end
        if (bus.i_mem_data_valid) begin
            outstanding_nx = outstanding_nx - CW'(1);
        end
        // On redirect nothing is requested, so whatever remains in flight is stale
        // (outstanding already covers any responses that were still to be dropped).
        drop_nx = drop_cnt;
        if (bus.i_redirect) begin
            drop_nx = outstanding_nx;
        end else if (rsp_drop) begin
            drop_nx = drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            fetch_pc    <= START_PC;
            resp_pc     <= START_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nx;
            drop_cnt    <= drop_nx;

            if (bus.i_redirect) begin
                fetch_pc <= bus.i_redirect_pc & ALIGN_MASK;
                resp_pc  <= bus.i_redirect_pc & ALIGN_MASK;
            end else begin
                if (req_acc) begin
                    fetch_pc <= fetch_pc + STEP;
                end
                if (rsp_keep) begin
                    resp_pc <= resp_pc + STEP;
                end
            end

            case (state)
                IDLE: begin
                    if (drop_nx != '0) state <= DRAIN;
                    else if (bus.i_en) state <= FETCH;
                end
                FETCH: begin
                    if (drop_nx != '0) state <= DRAIN;
                    else if (!bus.i_en) state <= IDLE;
                end
                DRAIN: begin
                    if (drop_nx == '0) state <= bus.i_en ? FETCH : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    if_prefetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rsp_keep),
        .push_dat ({resp_pc, bus.i_mem_data}),
        .pop      (pop),
        .flush    (bus.i_redirect),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign head_pc       = head_dat[ENT_W-1:DATA_W];
    assign bus.o_valid   = !fifo_empty;
    assign bus.o_instr   = fifo_empty ? '0 : head_dat[DATA_W-1:0];
    assign bus.o_pc      = fifo_empty ? '0 : head_pc;
    assign bus.o_pc_next = fifo_empty ? '0 : head_pc + STEP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized checks of instr_fetch_unit against a request/response-queue reference model.
module tb_instr_fetch_unit;

    logic clk;
    logic rst;

    instr_fetch_unit_if #(.DATA_W(32), .ADDR_W(32)) b ();
    instr_fetch_unit_if #(.DATA_W(32), .ADDR_W(32)) w ();

    instr_fetch_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          rdy;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    mreq_t       memq[$];
    ent_t        expq[$];
    logic [31:0] m_fetch_pc;
    int          epoch;
    int          cyc;
    int          obs_acc;
    int          vectors;
    int          miscompares;

    bit          k_en, k_en_rand, k_mem_on, k_force_redir;
    int          k_gnt, k_rdy, k_resp, k_lat, k_redir_pct;
    logic [31:0] k_redir_pc;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int n_stale();
        int n = 0;
        foreach (memq[i]) if (memq[i].epoch != epoch) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        memq.delete();
        expq.delete();
        m_fetch_pc = 32'h0;
        epoch++;
    endtask

    // One clock of stimulus, check and model update; entered and left at posedge+1.
    task automatic step();
        logic        en_v, redir_v, gnt_v, rdy_v, dv_v, exp_req;
        logic [31:0] rpc, nx;
        mreq_t       m;
        en_v    = k_en_rand ? ($urandom_range(0, 9) != 0) : k_en;
        redir_v = k_force_redir ||
                  (k_redir_pct != 0 && n_stale() == 0 && $urandom_range(0, 99) < k_redir_pct);
        rpc     = k_force_redir ? k_redir_pc : $urandom;
        gnt_v   = $urandom_range(0, 99) < k_gnt;
        rdy_v   = $urandom_range(0, 99) < k_rdy;
        dv_v    = k_mem_on && memq.size() != 0 && memq[0].rdy <= cyc
                  && $urandom_range(0, 99) < k_resp;
        b.i_en             = en_v;
        b.i_redirect       = redir_v;
        b.i_redirect_pc    = rpc;
        b.i_mem_gnt        = gnt_v;
        b.i_ready          = rdy_v;
        b.i_mem_data_valid = dv_v;
        b.i_mem_data       = dv_v ? mem_f(memq[0].addr) : $urandom;

        @(negedge clk);
        exp_req = en_v && !redir_v && (memq.size() + expq.size() < 4);
        chk("mem_req", b.o_mem_req, exp_req);
        if (exp_req) chk("mem_addr", b.o_mem_addr, m_fetch_pc);
        chk("valid", b.o_valid, expq.size() != 0);
        if (expq.size() != 0) begin
            nx = expq[0].pc + 32'd4;
            chk("pc", b.o_pc, expq[0].pc);
            chk("instr", b.o_instr, expq[0].instr);
            chk("pc_next", b.o_pc_next, nx);
        end
        if (b.o_mem_req && gnt_v) obs_acc++;

        if (!redir_v && rdy_v && expq.size() != 0) void'(expq.pop_front());
        if (dv_v) begin
            m = memq.pop_front();
            if (!redir_v && m.epoch == epoch) expq.push_back('{m.addr, mem_f(m.addr)});
        end
        if (exp_req && gnt_v) begin
            memq.push_back('{m_fetch_pc, epoch, cyc + $urandom_range(1, k_lat)});
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (redir_v) begin
            expq.delete();
            epoch++;
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
        end

        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic knobs(input bit en, input int gnt, input int rdy, input bit mem_on,
                         input int resp, input int lat);
        k_en = en; k_en_rand = 1'b0; k_gnt = gnt; k_rdy = rdy; k_mem_on = mem_on;
        k_resp = resp; k_lat = lat; k_redir_pct = 0; k_force_redir = 1'b0;
    endtask

    initial begin
        logic [31:0] wexp;
        int          base;
        vectors = 0; miscompares = 0; cyc = 0; obs_acc = 0; epoch = 0;
        k_redir_pc = 32'h0;
        rst = 1'b0;
        b.i_en = 1'b1; b.i_redirect = 1'b0; b.i_redirect_pc = '0; b.i_mem_gnt = 1'b1;
        b.i_mem_data = '0; b.i_mem_data_valid = 1'b0; b.i_ready = 1'b1;
        w.i_en = 1'b1; w.i_redirect = 1'b0; w.i_redirect_pc = '0; w.i_mem_gnt = 1'b1;
        w.i_mem_data = '0; w.i_mem_data_valid = 1'b0; w.i_ready = 1'b1;
        model_clear();

        // Reset state, with fetch enabled so the request gating is exercised.
        #12;
        chk("rst_mem_req", b.o_mem_req, 1'b0);
        chk("rst_valid", b.o_valid, 1'b0);
        chk("rst_instr", b.o_instr, 32'h0);
        chk("rst_pc", b.o_pc, 32'h0);
        chk("rst_pc_next", b.o_pc_next, 32'h0);
        chk("rst_wrap_req", w.o_mem_req, 1'b0);
        b.i_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Wrap-around fetch from RESET_PC 0xFFFFFFF8 with a 1-cycle memory.
        for (int c = 0; c < 6; c++) begin
            w.i_en             = (c < 3);
            w.i_mem_data_valid = (c >= 1 && c <= 3);
            wexp               = 32'hFFFF_FFF8 + 32'(4 * (c - 1));
            w.i_mem_data       = mem_f(wexp);
            @(negedge clk);
            wexp = 32'hFFFF_FFF8 + 32'(4 * c);
            if (c < 3) begin
                chk("wrap_req", w.o_mem_req, 1'b1);
                chk("wrap_addr", w.o_mem_addr, wexp);
            end
            if (c >= 2 && c <= 4) begin
                wexp = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
                chk("wrap_valid", w.o_valid, 1'b1);
                chk("wrap_pc", w.o_pc, wexp);
                chk("wrap_instr", w.o_instr, mem_f(wexp));
                wexp = wexp + 32'd4;
                chk("wrap_pc_next", w.o_pc_next, wexp);
            end
            @(posedge clk);
            #1;
        end
        w.i_en = 1'b0; w.i_mem_data_valid = 1'b0;

        // Straight-line streaming, 1-cycle memory, decode always ready.
        do_reset();
        knobs(1'b1, 100, 100, 1'b1, 100, 1);
        run(20);

        // Decode stalled: credit limits requests to the FIFO depth, head frozen.
        do_reset();
        knobs(1'b1, 100, 0, 1'b1, 100, 1);
        base = obs_acc;
        run(10);
        chk("stall_reqs", obs_acc - base, 4);
        chk("stall_head_pc", b.o_pc, 32'h0);
        chk("stall_req_off", b.o_mem_req, 1'b0);
        k_rdy = 100;
        run(8);

        // Redirect with 0x8/0xC in flight, response and pop in the same cycle.
        do_reset();
        knobs(1'b1, 100, 0, 1'b1, 100, 1);
        run(3);
        k_mem_on = 1'b0;
        run(1);
        k_mem_on = 1'b1; k_rdy = 100; k_force_redir = 1'b1; k_redir_pc = 32'h0000_0103;
        run(1);
        k_force_redir = 1'b0;
        chk("redir_flush", b.o_valid, 1'b0);
        chk("redir_addr", b.o_mem_addr, 32'h100);
        run(2);
        chk("redir_pc", b.o_pc, 32'h100);
        chk("redir_pc_next", b.o_pc_next, 32'h104);
        chk("redir_instr", b.o_instr, mem_f(32'h100));
        run(6);

        // Asynchronous reset with three requests in flight.
        do_reset();
        knobs(1'b1, 100, 0, 1'b1, 100, 1);
        run(2);
        k_mem_on = 1'b0;
        run(2);
        chk("pre_rst_valid", b.o_valid, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", b.o_valid, 1'b0);
        chk("async_rst_req", b.o_mem_req, 1'b0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        knobs(1'b1, 100, 100, 1'b1, 100, 1);
        run(10);

        // Randomized traffic: variable latency, grants, stalls, enable and redirects.
        knobs(1'b1, 70, 60, 1'b1, 70, 4);
        k_en_rand = 1'b1; k_redir_pct = 4;
        run(1500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
